// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, variable-latency memory bus between the
// instruction-fetch port and the data port. Data wins contention, bounded by a streak limit.
module mem_arbiter #(
    parameter int TIMEOUT      = 64,
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ren,
    input  logic [31:0] i_addr,
    output logic        ihit,
    output logic [31:0] i_load,
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_store,
    input  logic [1:0]  d_width,
    output logic        dhit,
    output logic [31:0] d_load,
    output logic        bus_err,
    output logic        m_ren,
    output logic        m_wen,
    output logic [31:0] m_addr,
    output logic [31:0] m_store,
    output logic [3:0]  m_byte_en,
    input  logic [31:0] m_rdata,
    input  logic        m_ready
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int STK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic [3:0] lane_be(input logic [1:0] width, input logic [1:0] a);
        logic [3:0] be;
        case (width)
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = 4'b0011 << {a[1], 1'b0};
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_store(input logic [1:0] width, input logic [31:0] st);
        logic [31:0] r;
        case (width)
            2'b00:   r = {4{st[7:0]}};
            2'b01:   r = {2{st[15:0]}};
            2'b10:   r = st;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Right-align the addressed lanes and zero everything above the access width.
    function automatic logic [31:0] lane_load(input logic [1:0] width, input logic [1:0] a,
                                              input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rdata >> {a, 3'b000};
        case (width)
            2'b00:   r = {24'h00_0000, sh[7:0]};
            2'b01:   r = {16'h0000, sh[15:0]};
            2'b10:   r = sh;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t            state_q,     state_d;
    logic              ihit_q,      ihit_d;
    logic              dhit_q,      dhit_d;
    logic              bus_err_q,   bus_err_d;
    logic [31:0]       i_load_q,    i_load_d;
    logic [31:0]       d_load_q,    d_load_d;
    logic              m_ren_q,     m_ren_d;
    logic              m_wen_q,     m_wen_d;
    logic [31:0]       m_addr_q,    m_addr_d;
    logic [31:0]       m_store_q,   m_store_d;
    logic [3:0]        m_byte_en_q, m_byte_en_d;
    logic [1:0]        a_lo_q,      a_lo_d;
    logic [1:0]        width_q,     width_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [STK_W-1:0]  streak_q,    streak_d;

    logic d_req_s;
    logic streak_full_s;
    logic grant_d_s;
    logic grant_i_s;

    // Arbitration decision for the current IDLE cycle.
    always_comb begin
        d_req_s       = d_ren | d_wen;
        streak_full_s = (streak_q == STK_MAX);
        grant_d_s     = (state_q == IDLE) && d_req_s && !(i_ren && streak_full_s);
        grant_i_s     = (state_q == IDLE) && !grant_d_s && i_ren;
    end

    // Next-state and next-output computation for the access FSM.
    always_comb begin
        state_d     = state_q;
        ihit_d      = 1'b0;
        dhit_d      = 1'b0;
        bus_err_d   = 1'b0;
        i_load_d    = i_load_q;
        d_load_d    = d_load_q;
        m_ren_d     = m_ren_q;
        m_wen_d     = m_wen_q;
        m_addr_d    = m_addr_q;
        m_store_d   = m_store_q;
        m_byte_en_d = m_byte_en_q;
        a_lo_d      = a_lo_q;
        width_d     = width_q;
        cnt_d       = cnt_q;

        // The streak only matters while fetch is actually waiting.
        if (grant_i_s || !i_ren) begin
            streak_d = '0;
        end else if (grant_d_s && !streak_full_s) begin
            streak_d = streak_q + STK_W'(1);
        end else begin
            streak_d = streak_q;
        end

        case (state_q)
            IDLE: begin
                if (grant_d_s) begin
                    a_lo_d  = d_addr[1:0];
                    width_d = d_width;
                    if (d_width == 2'b11) begin
                        state_d   = RESP;
                        dhit_d    = 1'b1;
                        bus_err_d = 1'b1;
                        d_load_d  = 32'h0000_0000;
                    end else begin
                        state_d     = D_ACC;
                        cnt_d       = '0;
                        m_addr_d    = {d_addr[31:2], 2'b00};
                        m_wen_d     = d_wen;
                        m_ren_d     = !d_wen;
                        m_byte_en_d = d_wen ? lane_be(d_width, d_addr[1:0]) : 4'b0000;
                        m_store_d   = d_wen ? lane_store(d_width, d_store) : 32'h0000_0000;
                    end
                end else if (grant_i_s) begin
                    state_d     = I_ACC;
                    cnt_d       = '0;
                    m_addr_d    = {i_addr[31:2], 2'b00};
                    m_ren_d     = 1'b1;
                    m_wen_d     = 1'b0;
                    m_byte_en_d = 4'b0000;
                    m_store_d   = 32'h0000_0000;
                end else begin
                    state_d = IDLE;
                end
            end
            I_ACC: begin
                if (m_ready) begin
                    state_d  = RESP;
                    ihit_d   = 1'b1;
                    i_load_d = m_rdata;
                    m_ren_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RESP;
                    ihit_d    = 1'b1;
                    bus_err_d = 1'b1;
                    i_load_d  = 32'h0000_0000;
                    m_ren_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            D_ACC: begin
                if (m_ready) begin
                    state_d  = RESP;
                    dhit_d   = 1'b1;
                    d_load_d = m_ren_q ? lane_load(width_q, a_lo_q, m_rdata) : 32'h0000_0000;
                    m_ren_d  = 1'b0;
                    m_wen_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RESP;
                    dhit_d    = 1'b1;
                    bus_err_d = 1'b1;
                    d_load_d  = 32'h0000_0000;
                    m_ren_d   = 1'b0;
                    m_wen_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                m_ren_d = 1'b0;
                m_wen_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs, synchronously reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ihit_q      <= 1'b0;
            dhit_q      <= 1'b0;
            bus_err_q   <= 1'b0;
            i_load_q    <= 32'h0000_0000;
            d_load_q    <= 32'h0000_0000;
            m_ren_q     <= 1'b0;
            m_wen_q     <= 1'b0;
            m_addr_q    <= 32'h0000_0000;
            m_store_q   <= 32'h0000_0000;
            m_byte_en_q <= 4'b0000;
            a_lo_q      <= 2'b00;
            width_q     <= 2'b00;
            cnt_q       <= '0;
            streak_q    <= '0;
        end else begin
            state_q     <= state_d;
            ihit_q      <= ihit_d;
            dhit_q      <= dhit_d;
            bus_err_q   <= bus_err_d;
            i_load_q    <= i_load_d;
            d_load_q    <= d_load_d;
            m_ren_q     <= m_ren_d;
            m_wen_q     <= m_wen_d;
            m_addr_q    <= m_addr_d;
            m_store_q   <= m_store_d;
            m_byte_en_q <= m_byte_en_d;
            a_lo_q      <= a_lo_d;
            width_q     <= width_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
        end
    end

    assign ihit      = ihit_q;
    assign dhit      = dhit_q;
    assign bus_err   = bus_err_q;
    assign i_load    = i_load_q;
    assign d_load    = d_load_q;
    assign m_ren     = m_ren_q;
    assign m_wen     = m_wen_q;
    assign m_addr    = m_addr_q;
    assign m_store   = m_store_q;
    assign m_byte_en = m_byte_en_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives both requester ports and emulates the memory; results are checked
// against a byte-level memory model and a transaction-level arbitration model.
module tb_mem_arbiter;

    localparam int TIMEOUT = 64;
    localparam int MAXS    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_ren;
    logic [31:0] i_addr;
    logic        ihit;
    logic [31:0] i_load;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_store;
    logic [1:0]  d_width;
    logic        dhit;
    logic [31:0] d_load;
    logic        bus_err;
    logic        m_ren;
    logic        m_wen;
    logic [31:0] m_addr;
    logic [31:0] m_store;
    logic [3:0]  m_byte_en;
    logic [31:0] m_rdata;
    logic        m_ready;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .i_ren(i_ren), .i_addr(i_addr), .ihit(ihit), .i_load(i_load),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_store(d_store), .d_width(d_width),
        .dhit(dhit), .d_load(d_load), .bus_err(bus_err),
        .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_store(m_store),
        .m_byte_en(m_byte_en), .m_rdata(m_rdata), .m_ready(m_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory seen by the DUT, and the independent byte-level reference.
    logic [31:0] mem   [int];
    logic [7:0]  ref_b [int];

    function automatic logic [31:0] init_word(input int w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] mem_rd(input int w);
        if (mem.exists(w)) return mem[w];
        else return init_word(w);
    endfunction

    function automatic logic [7:0] ref_byte(input int a);
        logic [31:0] w;
        if (ref_b.exists(a)) return ref_b[a];
        else begin
            w = init_word(a / 4);
            return w[8*(a%4) +: 8];
        end
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        return {ref_byte(a + 3), ref_byte(a + 2), ref_byte(a + 1), ref_byte(a)};
    endfunction

    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'b00) ? 1 : ((w == 2'b01) ? 2 : 4);
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] addr, input logic [1:0] w);
        logic [31:0] r;
        int a;
        r = 32'h0;
        a = int'(addr);
        for (int k = 0; k < nbytes(w); k++)
            if ((a % 4) + k < 4) r[8*k +: 8] = ref_byte(a + k);
        return r;
    endfunction

    function automatic logic [3:0] exp_be(input logic [31:0] addr, input logic [1:0] w);
        logic [3:0] be;
        be = 4'b0000;
        for (int k = 0; k < nbytes(w); k++)
            if (int'(addr[1:0]) + k < 4) be[int'(addr[1:0]) + k] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_mstore(input logic [1:0] w, input logic [31:0] st);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = st[8*(j % nbytes(w)) +: 8];
        return r;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [1:0] w, input logic [31:0] st);
        int a;
        a = int'(addr);
        for (int k = 0; k < nbytes(w); k++)
            if ((a % 4) + k < 4) ref_b[a + k] = st[8*k +: 8];
    endtask

    task automatic preload(input int a, input logic [31:0] v);
        mem[a / 4] = v;
        for (int j = 0; j < 4; j++) ref_b[a + j] = v[8*j +: 8];
    endtask

    // Memory responder state and first-cycle bus capture.
    int          lat_cfg  = 0;
    bit          rand_lat = 1'b0;
    int          lat_cur  = 0;
    int          acc_idx  = 0;
    int          strobe_total = 0;
    bit          ihit_now, dhit_now;
    bit          cap_valid = 1'b0;
    logic [31:0] cap_addr, cap_store;
    logic [3:0]  cap_be;
    logic        cap_ren, cap_wen;
    logic [31:0] last_dload;

    logic [1:0]  dl_op   [8];
    logic [31:0] dl_addr [8];
    logic [1:0]  dl_w    [8];
    logic [31:0] dl_st   [8];

    task automatic tick();
        logic [31:0] w;
        @(posedge clk);
        #1;
        ihit_now = ihit;
        dhit_now = dhit;
        m_ready  = 1'b0;
        m_rdata  = $urandom;
        if (m_ren || m_wen) begin
            if (acc_idx == 0) begin
                cap_valid = 1'b1;
                cap_addr  = m_addr;
                cap_store = m_store;
                cap_be    = m_byte_en;
                cap_ren   = m_ren;
                cap_wen   = m_wen;
                lat_cur   = rand_lat ? $urandom_range(0, 3) : lat_cfg;
            end
            strobe_total++;
            if (lat_cur >= 0 && acc_idx == lat_cur) begin
                m_ready = 1'b1;
                w = mem_rd(int'(m_addr[31:2]));
                m_rdata = w;
                if (m_wen) begin
                    for (int j = 0; j < 4; j++)
                        if (m_byte_en[j]) w[8*j +: 8] = m_store[8*j +: 8];
                    mem[int'(m_addr[31:2])] = w;
                end
            end
            acc_idx++;
        end else begin
            acc_idx = 0;
        end
    endtask

    task automatic drive_d(input int j);
        d_ren   = (dl_op[j] != 2'd1);
        d_wen   = (dl_op[j] != 2'd0);
        d_addr  = dl_addr[j];
        d_width = dl_w[j];
        d_store = dl_st[j];
    endtask

    // One scenario: optional fetch plus nd data ops, all raised together; order predicted
    // from the grant rules, data predicted from the byte-level reference.
    task automatic run_mix(input bit use_i, input logic [31:0] ia, input int nd, output int i_pos);
        int  exp_order[$];
        int  s, dr, di, k, extra;
        bit  ip, wr, to_mode;
        s = 0; dr = nd; ip = use_i; di = 0; k = 0; extra = 0; i_pos = -1;
        to_mode = (!rand_lat && lat_cfg < 0);
        while (ip || dr > 0) begin
            if (dr > 0 && !(ip && s == MAXS)) begin
                exp_order.push_back(1);
                dr--;
                s = ip ? ((s < MAXS) ? s + 1 : s) : 0;
            end else begin
                exp_order.push_back(0);
                ip = 1'b0;
                s  = 0;
            end
        end
        i_ren  = use_i;
        i_addr = ia;
        if (nd > 0) drive_d(0);
        cap_valid = 1'b0;
        for (int b = 0; b < 600 && k < exp_order.size(); b++) begin
            tick();
            if (ihit_now || dhit_now) begin
                check_eq("hit_excl", 32'(ihit_now & dhit_now), 32'd0);
                check_eq("hit_order", 32'(dhit_now), 32'(exp_order[k]));
                if (ihit_now) begin
                    i_pos = k;
                    check_eq("i_bus_seen", 32'(cap_valid), 32'd1);
                    check_eq("i_maddr", cap_addr, {ia[31:2], 2'b00});
                    check_eq("i_mren", 32'({cap_ren, cap_wen}), 32'd2);
                    check_eq("i_be", 32'(cap_be), 32'd0);
                    check_eq("i_err", 32'(bus_err), to_mode ? 32'd1 : 32'd0);
                    check_eq("i_load", i_load, to_mode ? 32'h0 : ref_word(int'(ia)));
                    i_ren = 1'b0;
                end else if (di < nd) begin
                    wr = (dl_op[di] != 2'd0);
                    last_dload = d_load;
                    if (dl_w[di] == 2'b11) begin
                        check_eq("w11_err", 32'(bus_err), 32'd1);
                        check_eq("w11_load", d_load, 32'h0);
                        check_eq("w11_nobus", 32'(cap_valid), 32'd0);
                    end else begin
                        check_eq("d_bus_seen", 32'(cap_valid), 32'd1);
                        check_eq("d_maddr", cap_addr, {dl_addr[di][31:2], 2'b00});
                        check_eq("d_strobe", 32'({cap_ren, cap_wen}), wr ? 32'd1 : 32'd2);
                        check_eq("d_be", 32'(cap_be), wr ? 32'(exp_be(dl_addr[di], dl_w[di])) : 32'd0);
                        if (wr) check_eq("d_mstore", cap_store, exp_mstore(dl_w[di], dl_st[di]));
                        check_eq("d_err", 32'(bus_err), to_mode ? 32'd1 : 32'd0);
                        if (to_mode) check_eq("d_load_to", d_load, 32'h0);
                        else if (wr) ref_store(dl_addr[di], dl_w[di], dl_st[di]);
                        else check_eq("d_load", d_load, exp_load(dl_addr[di], dl_w[di]));
                    end
                    di++;
                    if (di < nd) drive_d(di);
                    else begin d_ren = 1'b0; d_wen = 1'b0; end
                end else begin
                    extra++;
                end
                cap_valid = 1'b0;
                k++;
            end
        end
        check_eq("mix_done", 32'(k), 32'(exp_order.size()));
        i_ren = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
        for (int b = 0; b < 3; b++) begin
            tick();
            if (ihit_now || dhit_now) extra++;
        end
        check_eq("no_extra_hit", 32'(extra), 32'd0);
    endtask

    int  ipos;
    bit  hit_in_rst;
    bit  ui;
    int  nd;
    logic [31:0] ad;

    initial begin
        rst = 1'b1; i_ren = 1'b0; i_addr = 32'h0; d_ren = 1'b0; d_wen = 1'b0;
        d_addr = 32'h0; d_store = 32'h0; d_width = 2'b00; m_rdata = 32'h0; m_ready = 1'b0;
        preload(32'h100, 32'h0000_0013);
        preload(32'h400, 32'hBEEF_1234);
        repeat (3) tick();
        check_eq("rst_hits", 32'({ihit, dhit, bus_err, m_ren, m_wen}), 32'd0);
        check_eq("rst_maddr", m_addr, 32'h0);
        rst = 1'b0;
        tick();

        // Zero-wait fetch with exact cycle timing.
        i_addr = 32'h100; i_ren = 1'b1; lat_cfg = 0;
        tick();
        check_eq("f_c1_mren", 32'({m_ren, m_wen, ihit}), 32'd4);
        check_eq("f_c1_maddr", m_addr, 32'h100);
        tick();
        check_eq("f_c2_ihit", 32'(ihit), 32'd1);
        check_eq("f_c2_iload", i_load, 32'h0000_0013);
        check_eq("f_c2_err", 32'(bus_err), 32'd0);
        i_ren = 1'b0;
        tick();
        check_eq("f_c3_pulse", 32'(ihit), 32'd0);
        tick();

        // Contention: five loads against a held fetch.
        rand_lat = 1'b1;
        for (int j = 0; j < 5; j++) begin
            dl_op[j] = 2'd0; dl_w[j] = 2'b10; dl_addr[j] = 32'h300 + 32'(4*j); dl_st[j] = 32'h0;
        end
        run_mix(1'b1, 32'h104, 5, ipos);
        check_eq("contention_ipos", 32'(ipos), 32'd4);

        // Byte store into the top lane.
        dl_op[0] = 2'd1; dl_w[0] = 2'b00; dl_addr[0] = 32'h203; dl_st[0] = 32'h1234_56AB;
        run_mix(1'b0, 32'h0, 1, ipos);
        check_eq("bstore_maddr", cap_addr, 32'h200);
        check_eq("bstore_be", 32'(cap_be), 32'h8);
        check_eq("bstore_data", cap_store, 32'hABAB_ABAB);

        // Half load from the upper half-word.
        dl_op[0] = 2'd0; dl_w[0] = 2'b01; dl_addr[0] = 32'h402; dl_st[0] = 32'h0;
        run_mix(1'b0, 32'h0, 1, ipos);
        check_eq("hload_data", last_dload, 32'h0000_BEEF);

        // Illegal width: no bus cycle at all.
        strobe_total = 0;
        dl_op[0] = 2'd2; dl_w[0] = 2'b11; dl_addr[0] = 32'h310; dl_st[0] = 32'h5555_AAAA;
        run_mix(1'b0, 32'h0, 1, ipos);
        check_eq("w11_strobes", 32'(strobe_total), 32'd0);

        // Timeout on a load that memory never answers.
        rand_lat = 1'b0; lat_cfg = -1; strobe_total = 0;
        dl_op[0] = 2'd0; dl_w[0] = 2'b10; dl_addr[0] = 32'h320;
        run_mix(1'b0, 32'h0, 1, ipos);
        check_eq("to_strobes", 32'(strobe_total), 32'(TIMEOUT));

        // Randomized mixes.
        rand_lat = 1'b1;
        for (int it = 0; it < 40; it++) begin
            ui = 1'($urandom_range(0, 1));
            nd = $urandom_range(0, 6);
            if (!ui && nd == 0) nd = 1;
            for (int j = 0; j < nd; j++) begin
                dl_op[j] = 2'($urandom_range(0, 2));
                dl_w[j]  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                ad = 32'h300 + 32'($urandom_range(0, 63));
                if (dl_w[j] == 2'b01) ad[0] = 1'b0;
                else if (dl_w[j] == 2'b10) ad[1:0] = 2'b00;
                dl_addr[j] = ad;
                dl_st[j]   = $urandom;
            end
            run_mix(ui, 32'h100 + 32'($urandom_range(0, 63)) * 32'd4, nd, ipos);
        end

        // Reset in the middle of a data access abandons it.
        rand_lat = 1'b0; lat_cfg = -1; hit_in_rst = 1'b0;
        d_ren = 1'b1; d_wen = 1'b0; d_addr = 32'h304; d_width = 2'b10;
        repeat (5) begin tick(); if (dhit_now) hit_in_rst = 1'b1; end
        check_eq("pre_rst_mren", 32'(m_ren), 32'd1);
        rst = 1'b1;
        repeat (2) begin tick(); if (dhit_now) hit_in_rst = 1'b1; end
        check_eq("mid_rst_flags", 32'({ihit, dhit, bus_err, m_ren, m_wen}), 32'd0);
        check_eq("mid_rst_loads", i_load | d_load, 32'h0);
        check_eq("mid_rst_bus", m_addr | m_store | 32'(m_byte_en), 32'h0);
        rst = 1'b0; d_ren = 1'b0;
        repeat (4) begin tick(); if (dhit_now) hit_in_rst = 1'b1; end
        check_eq("rst_no_dhit", 32'(hit_in_rst), 32'd0);
        lat_cfg = 0;
        run_mix(1'b1, 32'h108, 0, ipos);
        check_eq("post_rst_fetch", 32'(ipos), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
